da_sample_sequencer: RTL
========================

# da_sample_sequencer

Control and output stage for the distributed-arithmetic FIR datapath. It accepts one parallel input sample per valid/ready handshake and loads it into the first subfilter's parallel-load shift register. It then drives the bit-serial run: `en` for WORD_WIDTH cycles, with `ts` marking the sign-bit cycle. On the final cycle it sums the `y` outputs of all subfilters into a registered result with its own valid/ready handshake.

## Interface
- WORD_WIDTH, 16, sample and subfilter output width; also the number of bit-serial cycles per sample.
- NUM_SUBFILTERS, 2, number of subfilter `y` words summed (≥1).
- OUT_WIDTH, WORD_WIDTH + $clog2(NUM_SUBFILTERS) (min WORD_WIDTH), derived localparam, result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  WORD_WIDTH  two's-complement input sample.
- x_we  out  1  parallel-load strobe to the first subfilter.
- x  out  WORD_WIDTH  load word to the first subfilter; equals in_data.
- en  out  1  shift/accumulate enable broadcast to all subfilters.
- ts  out  1  sign-bit (subtract) cycle flag broadcast to all subfilters.
- y_in  in  NUM_SUBFILTERS*WORD_WIDTH  concatenated subfilter `y`; subfilter k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_WIDTH  signed sum of subfilter outputs.
- busy  out  1  high while in RUN.

## Operation
- States:
  - IDLE: no run in progress; waits for an input handshake.
  - RUN: bit-serial run, tracked by bit counter `cnt` (width $clog2(WORD_WIDTH)).
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new run therefore never starts while an unconsumed result could be overwritten.
- Load: x_we = in_valid && in_ready (combinational); x = in_data always. en=0 and ts=0 on the load cycle.
- On load, IDLE→RUN with cnt=0.
- In RUN:
  - en=1 every cycle.
  - ts=1 only when cnt==WORD_WIDTH-1.
  - cnt increments each cycle.
  - At cnt==WORD_WIDTH-1: state→IDLE, cnt→0, and the result is captured.
- Capture: out_data ← Σ sign-extended y_in words, evaluated on the ts cycle (the subfilter `y` is combinational and complete on that cycle). out_valid←1 on the same edge.
- Result register:
  - out_valid clears on out_valid && out_ready.
  - out_data holds until the next capture.
  - Capture always lands in an empty slot, guaranteed by the in_ready rule.
- in_valid during RUN is ignored (in_ready=0); upstream must hold data.
- x_we, en and ts are mutually exclusive with respect to load versus run: x_we is never high together with en.
- Reset (async) returns every output and register to its reset value, including mid-RUN. The partially processed sample is discarded and no result is produced for it. Subfilter state is reset by the same rst.

## Timing
- Reset values: in_ready=1, x_we=0, en=0, ts=0, out_valid=0, out_data=0, busy=0; state=IDLE, cnt=0.
- Handshake at edge T (cycle T is the load cycle).
- RUN occupies cycles T+1 … T+WORD_WIDTH; ts is high in cycle T+WORD_WIDTH only.
- out_valid rises at cycle T+WORD_WIDTH+1, i.e. latency WORD_WIDTH+1 cycles from handshake to result.
- in_ready is high again in cycle T+WORD_WIDTH+1 if out_ready=1 that cycle or the result is already drained.
- Max throughput: one sample per WORD_WIDTH+1 cycles.
- Arithmetic:
  - Sign-extend each WORD_WIDTH word to OUT_WIDTH before adding; the sum cannot overflow.
  - No rounding or saturation.

## Test plan
- Reset then idle (WORD_WIDTH=16, NUM_SUBFILTERS=2):
  - Stimulus: rst pulse mid-cycle, in_valid=0 for 20 cycles.
  - Response: all outputs at reset values immediately (async), in_ready=1, en never asserted.
- Single sample:
  - Stimulus: in_data=16'h1234 handshake at T.
  - Response: x_we=1 and x=16'h1234 at T; en=1 for exactly 16 cycles; ts=1 only at T+16; out_valid=1 at T+17.
- Sum arithmetic, driving y_in at the ts cycle:
  - {16'h7FFF,16'h7FFF} → out_data=17'h0FFFE.
  - {16'h8000,16'h8000} → 17'h10000.
  - {16'hFF00,16'h0100} → 17'h00000.
- Backpressure:
  - Stimulus: out_ready=0 after the first result; in_valid held high.
  - Response: in_ready stays 0 and out_data stays stable. When out_ready goes to 1 for one cycle, the result drains and the next handshake occurs in that same cycle.
- Back-to-back with out_ready=1 and in_valid held high:
  - Response: handshakes every 17 cycles, en duty 16/17, and no result lost; check 4 samples against a reference model.
- Reset mid-run:
  - Stimulus: assert rst at cnt=7.
  - Response: en, ts and busy drop immediately, no out_valid is generated, and a following sample completes normally.

Source files
------------

// File: rtl/da_sample_sequencer.sv
// Sequencer for the distributed-arithmetic FIR: loads one sample per handshake, drives the
// WORD_WIDTH-cycle bit-serial run (en/ts), then registers the sign-extended sum of all subfilter outputs.
module da_sample_sequencer #(
   parameter int WORD_WIDTH     = 16,
   parameter int NUM_SUBFILTERS = 2,
   localparam int OUT_WIDTH     = WORD_WIDTH + $clog2(NUM_SUBFILTERS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [WORD_WIDTH-1:0]                in_data,
   output logic                                 x_we,
   output logic [WORD_WIDTH-1:0]                x,
   output logic                                 en,
   output logic                                 ts,
   input  logic [NUM_SUBFILTERS*WORD_WIDTH-1:0] y_in,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUT_WIDTH-1:0]                 out_data,
   output logic                                 busy
);

   localparam int CNT_W = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
   logic signed [OUT_WIDTH-1:0] sum;

   // A new run may only start when its result is guaranteed an empty slot on capture.
   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign x_we      = in_valid && in_ready;
   assign x         = in_data;
   assign en        = (state_q == RUN);
   assign ts        = (state_q == RUN) && (cnt_q == LAST_BIT);
   assign busy      = (state_q == RUN);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Signed size cast sign-extends each subfilter word before accumulation.
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_SUBFILTERS; k++) begin
         sum = sum + OUT_WIDTH'($signed(y_in[k*WORD_WIDTH +: WORD_WIDTH]));
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path through this block infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      unique case (state_q)
         IDLE: begin
            if (x_we) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (ts) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (ts) begin
         out_valid_d = 1'b1;
         out_data_d  = sum;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule
